inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Decoupling queue between the instruction fetch stage (`inst_rom` / `pc`) and the decode register (`if_id`) in the dual-issue front end. It accepts up to `FETCH_WIDTH` fetched instructions per cycle and presents up to `DECODER_WIDTH` of them, in program order, to the backend. It absorbs backend pause cycles without stalling fetch until the queue is full. All queued instructions are discarded on a pipeline flush.

## Interface
- `DEPTH`, 8: number of instruction entries; must be a power of two and ≥ 4.
- `FETCH_WIDTH`, 2: instructions offered per cycle.
- `DECODER_WIDTH`, 2: instructions presented per cycle.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all entries.
- `push_valid`  in  `FETCH_WIDTH`  per-slot valid for the offered instructions.
- `push_pc`  in  `bus32_t [FETCH_WIDTH]`  PC of each offered slot.
- `push_inst`  in  `bus32_t [FETCH_WIDTH]`  instruction word of each offered slot.
- `push_ready`  out  1  at least `FETCH_WIDTH` entries are free.
- `pop_ready`  in  1  backend consumes the presented instructions this cycle (not paused).
- `pop_valid`  out  `DECODER_WIDTH`  per-slot valid of the presented instructions.
- `pop_pc`  out  `bus32_t [DECODER_WIDTH]`  PC of each presented slot.
- `pop_inst`  out  `bus32_t [DECODER_WIDTH]`  instruction word of each presented slot.
- `count`  out  `$clog2(DEPTH+1)`  number of occupied entries.

## Operation
- Storage is a circular buffer of `fetch_entry_t` entries.
  - `head` and `tail` are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
  - `count` is kept as a separate register.
- **Push:** occurs when `push_ready` is 1 and at least one `push_valid` bit is set.
  - Valid slots are compacted and written in slot order starting at `tail`. For example, `push_valid=2'b10` writes slot 1 at `tail`.
  - `push_n` = popcount(`push_valid`). `tail` advances by `push_n`.
  - When `push_ready` is 0, the offered slots are ignored and no state changes. Fetch is responsible for re-presenting them.
- **Pop:** `pop_valid[i] = (count > i)`.
  - `pop_pc[i]` and `pop_inst[i]` come from entry `head+i` when valid; otherwise they are 0.
  - When `pop_ready` is 1, `pop_n` = min(`count`, `DECODER_WIDTH`) and `head` advances by `pop_n`. Partial consumption is not supported.
- **Simultaneous push and pop:** `count_next = count + push_n − pop_n`. Because `push_ready` is computed from the current `count`, a same-cycle pop is never needed to make room.
- **Flush:** highest priority after reset.
  - Next cycle: `head`, `tail` and `count` are all 0.
  - A push and a pop in the same cycle as the flush are both discarded.
- **Reset** (`rst`=0 at a clock edge): clears the same state as flush. Reset in the middle of an operation abandons all entries.

## Timing
- Reset values: `count`=0, `push_ready`=1, `pop_valid`=0, `pop_pc`=0, `pop_inst`=0.
- Latency is one cycle with no bypass. An instruction pushed at edge N is visible on `pop_*` from cycle N+1.
- `push_ready = (DEPTH − count) ≥ FETCH_WIDTH`. It depends only on registers, so there is no combinational path from `pop_ready` or `push_valid`.
- `pop_*` are combinational reads of registered state; they have no path from `pop_ready`.
- Boundaries:
  - Full (`count` = `DEPTH`): `push_ready`=0.
  - `count` = `DEPTH−1`: `push_ready`=0. One free entry is never used by a 2-wide push.
  - Empty: `pop_valid`=0, and `pop_ready` has no effect.
  - Wrap: entries at index `DEPTH−1` and index 0 are presented together as slots 0 and 1.

## Structure
- Add to `pipeline_types`:
  - `FETCH_WIDTH`, alongside the existing `DECODER_WIDTH`.
  - `typedef struct packed { bus32_t pc; bus32_t inst; } fetch_entry_t`.
- The block is a single module with no sub-module; storage is a flat register array.
- In `cpu_spoc`, the block sits between the `inst_rom` outputs and `if_id`:
  - `push_ready` gates `inst_en`.
  - `pop_ready = ~pause[1]`.
  - `flush = flush[1]`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `push_valid`=2'b11 → `count`=0, `push_ready`=1, `pop_valid`=2'b00, `pop_pc`=0.
- **Basic push:** `pop_ready`=0; push pc 0x1c000000/inst 0x02800421 and pc 0x1c000004/inst 0x02800842 → next cycle `count`=2, `pop_valid`=2'b11, `pop_pc[0]`=0x1c000000, `pop_inst[1]`=0x02800842.
- **Fill:** `pop_ready`=0; four 2-wide pushes → `count`=8, `push_ready`=0; a fifth push of pc 0x1c000020 is ignored and `count` stays 8.
- **Wrap:** at `count`=4 with `head`=6, push 2 and pop 2 for 6 cycles → `count` stays 4; PCs emerge in strictly ascending +4 order across the 7→0 wrap.
- **Compaction and partial pop:** `push_valid`=2'b10 (pc A), then 2'b01 (pc B) → `pop_pc[0]`=A, `pop_pc[1]`=B. Then pop with `count`=1 → `pop_valid`=2'b01, and `count`=0 afterwards.
- **Flush:** at `count`=6, assert `flush` together with a push and `pop_ready`=1 → next cycle `count`=0 and `pop_valid`=2'b00. A push on the following cycle appears at slot 0.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared front-end types and widths for the fetch queue.
//   bus32_t       : 32-bit datapath word
//   IFQ_DEPTH     : default queue depth (entries)
//   FETCH_WIDTH   : instructions offered per cycle by fetch
//   DECODER_WIDTH : instructions presented per cycle to decode
//   fetch_entry_t : one queued instruction (pc + word)
package inst_fetch_queue_pkg;
  typedef logic [31:0] bus32_t;
  localparam int IFQ_DEPTH = 8;
  localparam int FETCH_WIDTH = 2;
  localparam int DECODER_WIDTH = 2;
  typedef struct packed {
    bus32_t pc;
    bus32_t inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch-side push bus, decode-side pop bus, flush and occupancy.
//   flush                       : discard all queued entries
//   push_valid/push_pc/push_inst: offered instructions, one per slot
//   push_ready                  : room for a full-width push
//   pop_ready                   : decode consumes the presented slots
//   pop_valid/pop_pc/pop_inst   : presented instructions in program order
//   count                       : occupied entries
//   slave modport is the queue, master modport is the driver.
interface inst_fetch_queue_if #(
  parameter int DEPTH = inst_fetch_queue_pkg::IFQ_DEPTH,
  parameter int FETCH_WIDTH = inst_fetch_queue_pkg::FETCH_WIDTH,
  parameter int DECODER_WIDTH = inst_fetch_queue_pkg::DECODER_WIDTH
) ();
  import inst_fetch_queue_pkg::*;
  logic flush;
  logic [FETCH_WIDTH-1:0] push_valid;
  bus32_t [FETCH_WIDTH-1:0] push_pc;
  bus32_t [FETCH_WIDTH-1:0] push_inst;
  logic push_ready;
  logic pop_ready;
  logic [DECODER_WIDTH-1:0] pop_valid;
  bus32_t [DECODER_WIDTH-1:0] pop_pc;
  bus32_t [DECODER_WIDTH-1:0] pop_inst;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output flush, push_valid, push_pc, push_inst, pop_ready,
    input push_ready, pop_valid, pop_pc, pop_inst, count
  );
  modport slave (
    input flush, push_valid, push_pc, push_inst, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_inst, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular decoupling queue between fetch and the decode register.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : inst_fetch_queue_if.slave (push/pop handshakes, flush, count)
module inst_fetch_queue #(
  parameter int DEPTH = inst_fetch_queue_pkg::IFQ_DEPTH,
  parameter int FETCH_WIDTH = inst_fetch_queue_pkg::FETCH_WIDTH,
  parameter int DECODER_WIDTH = inst_fetch_queue_pkg::DECODER_WIDTH
) (
  input logic clk,
  input logic rst,
  inst_fetch_queue_if.slave bus
);
  import inst_fetch_queue_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_push_n, w_pop_n;
  logic [AW-1:0] w_off [FETCH_WIDTH];
  logic w_push_ready, w_push;
  // Compaction: each valid slot lands at tail plus the number of valid slots below it.
  always_comb begin
    w_push_n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_off[i] = w_push_n[AW-1:0];
      w_push_n = w_push_n + CW'(bus.push_valid[i]);
    end
  end
  assign w_push_ready = r_count <= CW'(DEPTH - FETCH_WIDTH);
  assign w_push = w_push_ready && |bus.push_valid;
  assign w_pop_n = !bus.pop_ready ? '0 :
                   r_count < CW'(DECODER_WIDTH) ? r_count : CW'(DECODER_WIDTH);
  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_head <= r_head + w_pop_n[AW-1:0];
      r_tail <= w_push ? r_tail + w_push_n[AW-1:0] : r_tail;
      r_count <= r_count + (w_push ? w_push_n : '0) - w_pop_n;
    end
  end
  // Storage needs no reset: stale entries are masked by pop_valid.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && w_push)
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (bus.push_valid[i]) r_mem[r_tail + w_off[i]] <= '{pc: bus.push_pc[i], inst: bus.push_inst[i]};
  end
  always_comb begin
    for (int i = 0; i < DECODER_WIDTH; i++) begin
      bus.pop_valid[i] = r_count > CW'(i);
      bus.pop_pc[i] = bus.pop_valid[i] ? r_mem[r_head + AW'(i)].pc : '0;
      bus.pop_inst[i] = bus.pop_valid[i] ? r_mem[r_head + AW'(i)].inst : '0;
    end
  end
  assign bus.push_ready = w_push_ready;
  assign bus.count = r_count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed and random checks of the fetch queue against a queue model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  fetch_entry_t mq [$];
  bus32_t nxt, ep, pa, pb, pd;
  always #5 clk = ~clk;
  inst_fetch_queue_if bus ();
  inst_fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("push_ready", 32'(bus.push_ready), 32'(mq.size() <= 6));
    for (int i = 0; i < 2; i++) begin
      chk("pop_valid", 32'(bus.pop_valid[i]), 32'(mq.size() > i));
      chk("pop_pc", bus.pop_pc[i], mq.size() > i ? mq[i].pc : 32'h0);
      chk("pop_inst", bus.pop_inst[i], mq.size() > i ? mq[i].inst : 32'h0);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic [1:0] pv,
                       input bus32_t p0, input bus32_t i0, input bus32_t p1, input bus32_t i1,
                       input logic pr);
    int n;
    rst = r;
    bus.flush = f;
    bus.push_valid = pv;
    bus.push_pc = {p1, p0};
    bus.push_inst = {i1, i0};
    bus.pop_ready = pr;
    n = mq.size();
    if (!r || f) mq.delete();
    else begin
      if (pr) repeat (n < 2 ? n : 2) void'(mq.pop_front());
      if (8 - n >= 2) begin
        if (pv[0]) mq.push_back('{pc: p0, inst: i0});
        if (pv[1]) mq.push_back('{pc: p1, inst: i1});
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic push2(input logic pr);
    cycle(1, 0, 2'b11, nxt, ~nxt, nxt + 4, ~(nxt + 4), pr);
    nxt += 8;
  endtask

  initial begin
    rst = 0;
    bus.flush = 0;
    bus.push_valid = 0;
    bus.push_pc = '0;
    bus.push_inst = '0;
    bus.pop_ready = 0;
    #1;
    cycle(0, 0, 2'b11, 32'h1c000000, 32'h1, 32'h1c000004, 32'h2, 0);
    cycle(0, 0, 2'b11, 32'h1c000000, 32'h1, 32'h1c000004, 32'h2, 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_push_ready", 32'(bus.push_ready), 1);
    chk("rst_pop_valid", 32'(bus.pop_valid), 0);
    chk("rst_pop_pc", bus.pop_pc[0], 0);
    cycle(1, 0, 2'b11, 32'h1c000000, 32'h02800421, 32'h1c000004, 32'h02800842, 0);
    chk("basic_count", 32'(bus.count), 2);
    chk("basic_pop_valid", 32'(bus.pop_valid), 3);
    chk("basic_pop_pc0", bus.pop_pc[0], 32'h1c000000);
    chk("basic_pop_inst1", bus.pop_inst[1], 32'h02800842);
    nxt = 32'h1c000008;
    repeat (3) push2(0);
    chk("fill_count", 32'(bus.count), 8);
    chk("fill_push_ready", 32'(bus.push_ready), 0);
    cycle(1, 0, 2'b11, 32'h1c000020, 32'h5, 32'h1c000024, 32'h6, 0);
    chk("full_count", 32'(bus.count), 8);
    chk("full_head_pc", bus.pop_pc[0], 32'h1c000000);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 0);
    cycle(1, 0, 2'b00, 0, 0, 0, 0, 1);
    chk("empty_pop_count", 32'(bus.count), 0);
    nxt = 32'h1c000100;
    ep = 32'h1c000100;
    repeat (3) push2(0);
    chk("wrap_pre_pc", bus.pop_pc[0], ep);
    cycle(1, 0, 2'b00, 0, 0, 0, 0, 1);
    ep += 8;
    repeat (2) begin
      chk("wrap_lead_pc0", bus.pop_pc[0], ep);
      push2(1);
      ep += 8;
    end
    repeat (6) begin
      chk("wrap_pc0", bus.pop_pc[0], ep);
      chk("wrap_pc1", bus.pop_pc[1], ep + 4);
      push2(1);
      ep += 8;
      chk("wrap_count", 32'(bus.count), 4);
    end
    cycle(1, 1, 2'b00, 0, 0, 0, 0, 0);
    pa = 32'h1c000200;
    pb = 32'h1c000204;
    cycle(1, 0, 2'b10, 32'hdead0000, 32'h0, pa, 32'ha, 0);
    cycle(1, 0, 2'b01, pb, 32'hb, 32'hdead0004, 32'h0, 0);
    chk("compact_pc0", bus.pop_pc[0], pa);
    chk("compact_pc1", bus.pop_pc[1], pb);
    cycle(1, 0, 2'b01, 32'h1c000208, 32'hc, 0, 0, 1);
    chk("partial_pop_valid", 32'(bus.pop_valid), 1);
    cycle(1, 0, 2'b00, 0, 0, 0, 0, 1);
    chk("partial_count", 32'(bus.count), 0);
    nxt = 32'h1c000300;
    repeat (3) push2(0);
    chk("flush_pre_count", 32'(bus.count), 6);
    cycle(1, 1, 2'b11, 32'h1c000400, 32'h7, 32'h1c000404, 32'h8, 1);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_pop_valid", 32'(bus.pop_valid), 0);
    pd = 32'h1c000500;
    cycle(1, 0, 2'b01, pd, 32'hd, 0, 0, 0);
    chk("post_flush_pc0", bus.pop_pc[0], pd);
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 2) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
